serial_addsub: RTL

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/addsub_pkg.sv | 6 +
 rtl/addsub_digit.sv | 23 ++
 rtl/serial_addsub.sv | 90 +++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared FSM state encoding and op constants for serial_addsub.
package addsub_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/addsub_digit.sv
// addsub_digit: combinational DIGIT-wide ripple add (sub=0) or borrow-subtract (sub=1) slice.
module addsub_digit #(
   parameter int DIGIT = 2
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             cin,
   input  logic             sub,
   output logic [DIGIT-1:0] s,
   output logic             cout
);
   logic cc;
   always_comb begin
      cc = cin;
      s = '0;
      for (int i = 0; i < DIGIT; i++) begin
         s[i] = x[i] ^ y[i] ^ cc;
         cc = sub ? ((~x[i] & y[i]) | (~(x[i] ^ y[i]) & cc))
                  : ((x[i] & y[i]) | ((x[i] ^ y[i]) & cc));
      end
      cout = cc;
   end
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial add/subtract with valid/ready handshakes.
// Define SERIAL_ADDSUB_SAT_EN for unsigned saturation of the low result bits.
module serial_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   result,
   output logic             ovf
);
   localparam int N = WIDTH / DIGIT;
   localparam int CW = N > 1 ? $clog2(N) : 1;
   state_t state, nxt;
   logic [WIDTH-1:0] a_r, b_r, lo, lo_nx, fin_lo;
   logic [WIDTH+DIGIT-1:0] sh;
   logic [DIGIT-1:0] s;
   logic [CW-1:0] cnt;
   logic op_r, c, cout, sa, sb, cf, live, accept;
   addsub_digit #(.DIGIT(DIGIT)) u_digit (
      .x(a_r[DIGIT-1:0]), .y(b_r[DIGIT-1:0]), .cin(c), .sub(op_r), .s(s), .cout(cout)
   );
   // live holds in_ready low until the first edge after reset release
   assign in_ready = state == IDLE && live;
   assign out_valid = state == DONE;
   assign accept = in_valid && in_ready;
   assign result = {cf, lo};
   assign sh = {s, lo};
   assign lo_nx = sh[WIDTH+DIGIT-1:DIGIT];
`ifdef SERIAL_ADDSUB_SAT_EN
   assign fin_lo = cout ? {WIDTH{op_r == OP_ADD}} : lo_nx;
`else
   assign fin_lo = lo_nx;
`endif
   always_comb begin
      nxt = (state == IDLE && accept) ? BUSY :
            (state == BUSY && cnt == '0) ? DONE :
            (state == DONE && out_ready) ? IDLE : state;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else state <= nxt;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         live <= 1'b0;
         a_r <= '0;
         b_r <= '0;
         op_r <= OP_ADD;
         c <= 1'b0;
         cnt <= '0;
         sa <= 1'b0;
         sb <= 1'b0;
         lo <= '0;
         cf <= 1'b0;
         ovf <= 1'b0;
      end else begin
         live <= 1'b1;
         if (accept) begin
            a_r <= a;
            b_r <= b;
            op_r <= op;
            c <= 1'b0;
            cnt <= CW'(N - 1);
            sa <= a[WIDTH-1];
            sb <= b[WIDTH-1];
         end else if (state == BUSY) begin
            a_r <= a_r >> DIGIT;
            b_r <= b_r >> DIGIT;
            c <= cout;
            cnt <= cnt - 1'b1;
            lo <= cnt == '0 ? fin_lo : lo_nx;
            if (cnt == '0) begin
               cf <= cout;
               // subtract flips the effective sign of b
               ovf <= (sa == (sb ^ op_r)) && (s[DIGIT-1] != sa);
            end
         end
      end
   end
endmodule
